mem_access_unit: RTL and testbench

- Load/store front-end between the CPU datapath and the word-only data memory (DM).
- DM writes only whole words, so sub-word stores (sb/sh) are done here as read-modify-write.
- Sub-word loads (lb/lbu/lh/lhu) are extracted and extended here.
- Misaligned and out-of-range accesses are flagged.
- Single outstanding request, valid/ready on the request side, one-cycle response pulse.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only data memory: sub-word stores become
// read-modify-write sequences, sub-word loads are extracted and extended here.
module mem_access_unit #(
   parameter int MEM_WORDS = 3072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wd,
   output logic        dm_we,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_rdata
);

   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q,      state_d;
   logic        we_q,         we_d;
   logic [1:0]  size_q,       size_d;
   logic        sgn_q,        sgn_d;
   logic [1:0]  lane_q,       lane_d;
   logic [31:0] wdata_q,      wdata_d;
   logic [31:0] dm_addr_q,    dm_addr_d;
   logic [31:0] dm_pc_q,      dm_pc_d;
   logic [31:0] dm_wd_q,      dm_wd_d;
   logic        dm_we_q,      dm_we_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q,   resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        req_ready_q,  req_ready_d;
   logic        req_bad;

   // Replace the addressed byte or half of a memory word; word size passes wd through.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00: begin
            case (lane)
               2'd0: r[7:0]   = wd[7:0];
               2'd1: r[15:8]  = wd[7:0];
               2'd2: r[23:16] = wd[7:0];
               default: r[31:24] = wd[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) r[31:16] = wd[15:0];
            else         r[15:0]  = wd[15:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        sgn,
                                                input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
         2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   always_comb begin
      req_bad = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
             || ({1'b0, req_addr} >= MEM_BYTES);
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      dm_addr_d    = dm_addr_q;
      dm_pc_d      = dm_pc_q;
      dm_wd_d      = dm_wd_q;
      dm_we_d      = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d      = req_we;
               size_d    = req_size;
               sgn_d     = req_signed;
               lane_d    = req_addr[1:0];
               wdata_d   = req_wdata;
               dm_addr_d = {req_addr[31:2], 2'b00};
               dm_pc_d   = req_pc;
               if (req_bad) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_we && req_size == 2'b10) begin
                  state_d = WR;
                  dm_we_d = 1'b1;
                  dm_wd_d = req_wdata;
               end else begin
                  state_d = RD;
               end
            end
         end
         // The read word is consumed on the way out of RD: merged for stores, extracted for loads.
         RD: begin
            if (we_q) begin
               state_d = WR;
               dm_we_d = 1'b1;
               dm_wd_d = store_merge(dm_rdata, wdata_q, size_q, lane_q);
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extract(dm_rdata, size_q, sgn_q, lane_q);
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
   end

   // Outputs are registered alongside the state so async reset clears dm_we immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         sgn_q        <= 1'b0;
         lane_q       <= 2'b00;
         wdata_q      <= 32'd0;
         dm_addr_q    <= 32'd0;
         dm_pc_q      <= 32'd0;
         dm_wd_q      <= 32'd0;
         dm_we_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         req_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         sgn_q        <= sgn_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
         dm_addr_q    <= dm_addr_d;
         dm_pc_q      <= dm_pc_d;
         dm_wd_q      <= dm_wd_d;
         dm_we_q      <= dm_we_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign dm_addr    = dm_addr_q;
   assign dm_wd      = dm_wd_q;
   assign dm_we      = dm_we_q;
   assign dm_pc      = dm_pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vector table, hand-written multi-cycle sequences,
// and random requests checked against an array-based memory model.
module tb_mem_access_unit;

   localparam int NW = 3072;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic        dm_we;
   logic [31:0] dm_pc;
   logic [31:0] dm_rdata;

   logic [31:0] mem     [0:NW-1];
   logic [31:0] ref_mem [0:NW-1];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign dm_rdata = (dm_addr[31:2] < 30'(NW)) ? mem[dm_addr[13:2]] : 32'd0;

   mem_access_unit #(.MEM_WORDS(NW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_pc(dm_pc),
      .dm_rdata(dm_rdata)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic        chk_mem;
      logic [31:0] exp_word;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Reference: what the request should return and how memory should look afterwards.
   task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] exp_rdata, output logic exp_err,
                        output int exp_lat);
      int unsigned idx, sh;
      logic [31:0] w, v, mask;
      exp_rdata = 0;
      exp_err = (size == 3) || (size == 1 && addr % 2 != 0) ||
                (size == 2 && addr % 4 != 0) || (addr >= NW * 4);
      if (exp_err) begin
         exp_lat = 1;
         return;
      end
      idx = addr / 4;
      w   = ref_mem[idx];
      if (size == 0) sh = 8 * (addr % 4);
      else           sh = 16 * ((addr % 4) / 2);
      mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (we) begin
         exp_lat = (size == 2) ? 2 : 3;
         ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      end else begin
         exp_lat = 2;
         v = (w >> sh) & mask;
         if (sgn && size == 0 && v >= 128)   v = v + 32'hFFFF_FF00;
         if (sgn && size == 1 && v >= 32768) v = v + 32'hFFFF_0000;
         exp_rdata = v;
      end
   endtask

   // Starts at a falling edge with the unit idle; returns at a falling edge.
   task automatic run_req(input string nm, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
      int first_c = 0, pulses = 0, we_n = 0;
      logic [31:0] got_rdata = 0;
      logic got_err = 0;
      check({nm, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr;
      req_wdata = wdata; req_pc = pc; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) check({nm, ".ready_busy"}, {31'd0, req_ready}, 32'd0);
         if (c == exp_lat + 1) check({nm, ".ready_back"}, {31'd0, req_ready}, 32'd1);
         if (dm_we) begin
            we_n++;
            check({nm, ".dm_addr"}, dm_addr, {addr[31:2], 2'b00});
            check({nm, ".dm_pc"}, dm_pc, pc);
            if (dm_addr[31:2] < 30'(NW)) mem[dm_addr[13:2]] = dm_wd;
         end
         if (resp_valid) begin
            pulses++;
            if (first_c == 0) begin
               first_c   = c;
               got_rdata = resp_rdata;
               got_err   = resp_err;
            end
         end
      end
      check({nm, ".latency"}, first_c, exp_lat);
      check({nm, ".pulses"}, pulses, 1);
      check({nm, ".dm_we_count"}, we_n, (we && !exp_err) ? 1 : 0);
      check({nm, ".rdata"}, got_rdata, exp_rdata);
      check({nm, ".err"}, {31'd0, got_err}, {31'd0, exp_err});
   endtask

   initial begin
      logic [31:0] m_rdata, a, wd;
      logic        m_err, we, sgn;
      logic [1:0]  sz;
      int          m_lat, widx, seen;

      for (int i = 0; i < NW; i++) begin
         mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      mem[8] = 32'hAABB_CCDD;
      ref_mem[8] = 32'hAABB_CCDD;

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst.ready", {31'd0, req_ready}, 32'd1);
      check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst.resp_err", {31'd0, resp_err}, 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'd0);
      check("rst.dm_we", {31'd0, dm_we}, 32'd0);
      check("rst.dm_addr", dm_addr, 32'd0);
      check("rst.dm_wd", dm_wd, 32'd0);
      check("rst.dm_pc", dm_pc, 32'd0);

      tbl[0]  = '{"sw_10",     1, 2, 0, 32'h10,   32'h1234_5678, 32'h0,         0, 2, 1, 32'h1234_5678};
      tbl[1]  = '{"lw_10",     0, 2, 0, 32'h10,   32'h0,         32'h1234_5678, 0, 2, 0, 32'h0};
      tbl[2]  = '{"sb_22",     1, 0, 0, 32'h22,   32'hEEEE_EE11, 32'h0,         0, 3, 1, 32'hAA11_CCDD};
      tbl[3]  = '{"lb_20",     0, 0, 1, 32'h20,   32'h0,         32'hFFFF_FFDD, 0, 2, 0, 32'h0};
      tbl[4]  = '{"lbu_23",    0, 0, 0, 32'h23,   32'h0,         32'h0000_00AA, 0, 2, 0, 32'h0};
      tbl[5]  = '{"lh_22",     0, 1, 1, 32'h22,   32'h0,         32'hFFFF_AA11, 0, 2, 0, 32'h0};
      tbl[6]  = '{"lhu_20",    0, 1, 0, 32'h20,   32'h0,         32'h0000_CCDD, 0, 2, 0, 32'h0};
      tbl[7]  = '{"sh_21_err", 1, 1, 0, 32'h21,   32'h0000_BEEF, 32'h0,         1, 1, 1, 32'hAA11_CCDD};
      tbl[8]  = '{"lw_22_err", 0, 2, 0, 32'h22,   32'h0,         32'h0,         1, 1, 0, 32'h0};
      tbl[9]  = '{"sz3_err",   0, 3, 1, 32'h24,   32'h0,         32'h0,         1, 1, 0, 32'h0};
      tbl[10] = '{"sw_oob",    1, 2, 0, 32'h3000, 32'h5555_5555, 32'h0,         1, 1, 0, 32'h0};
      tbl[11] = '{"sw_top",    1, 2, 0, 32'h2FFC, 32'hCAFE_F00D, 32'h0,         0, 2, 1, 32'hCAFE_F00D};
      tbl[12] = '{"lh_top",    0, 1, 1, 32'h2FFE, 32'h0,         32'hFFFF_CAFE, 0, 2, 0, 32'h0};
      tbl[13] = '{"lbu_top",   0, 0, 0, 32'h2FFF, 32'h0,         32'h0000_00CA, 0, 2, 0, 32'h0};
      tbl[14] = '{"sh_12",     1, 1, 0, 32'h12,   32'h7777_8001, 32'h0,         0, 3, 1, 32'h8001_5678};
      tbl[15] = '{"lw_10b",    0, 2, 0, 32'h10,   32'h0,         32'h8001_5678, 0, 2, 0, 32'h0};

      for (int i = 0; i < 16; i++) begin
         model(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, m_rdata, m_err, m_lat);
         run_req(tbl[i].name, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                 32'h1000 + 32'(i * 4), tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
         if (tbl[i].chk_mem) check({tbl[i].name, ".mem"}, mem[tbl[i].addr[13:2]], tbl[i].exp_word);
      end

      // Back-to-back: valid stays high, second request waits until after RESP.
      req_we = 0; req_size = 2; req_signed = 0; req_addr = 32'h10; req_pc = 32'h2000;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_size = 1; req_addr = 32'h20; req_pc = 32'h2004;
      @(negedge clk);
      check("b2b.c1_ready", {31'd0, req_ready}, 32'd0);
      check("b2b.c1_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check("b2b.c2_ready", {31'd0, req_ready}, 32'd0);
      check("b2b.c2_resp", {31'd0, resp_valid}, 32'd1);
      check("b2b.c2_rdata", resp_rdata, 32'h8001_5678);
      check("b2b.c2_pc", dm_pc, 32'h2000);
      @(negedge clk);
      check("b2b.c3_ready", {31'd0, req_ready}, 32'd1);
      check("b2b.c3_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b.c4_ready", {31'd0, req_ready}, 32'd0);
      check("b2b.c4_pc", dm_pc, 32'h2004);
      @(negedge clk);
      check("b2b.c5_resp", {31'd0, resp_valid}, 32'd1);
      check("b2b.c5_rdata", resp_rdata, 32'h0000_CCDD);
      @(negedge clk);
      check("b2b.c6_ready", {31'd0, req_ready}, 32'd1);

      // Reset asserted during the WR cycle of a word store.
      req_we = 1; req_size = 2; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
      req_pc = 32'h3000; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("rstwr.dm_we_before", {31'd0, dm_we}, 32'd1);
      #2 reset = 1'b1;
      #1 check("rstwr.dm_we_after", {31'd0, dm_we}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid || dm_we) seen++;
      end
      check("rstwr.no_activity", seen, 0);
      check("rstwr.ready", {31'd0, req_ready}, 32'd1);
      check("rstwr.mem", mem[16], 32'd0);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 32'h3000 + $urandom_range(0, 15);
            1:       a = 32'h2FF0 + $urandom_range(0, 15);
            default: a = $urandom_range(0, 63);
         endcase
         widx = $urandom_range(0, 9);
         sz   = (widx == 9) ? 2'b11 : 2'(widx % 3);
         we   = 1'($urandom_range(0, 1));
         sgn  = 1'($urandom_range(0, 1));
         wd   = $urandom;
         model(we, sz, sgn, a, wd, m_rdata, m_err, m_lat);
         run_req("rand", we, sz, sgn, a, wd, $urandom, m_rdata, m_err, m_lat);
         if (we && a < NW * 4) check("rand.mem", mem[a[13:2]], ref_mem[a[13:2]]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
